// File: rtl/fifo_ctl_ram_pkg.sv
// Shared constants for the DMA channel data FIFO: default geometry and tag field positions.
package fifo_ctl_ram_pkg;

  localparam int ADDR_LENGTH_DEF = 9;
  localparam int DATA_WIDTH_DEF  = 72;

  // Upper byte of each entry is the tag; its MSB marks the last word of a stream.
  localparam int TAG_LSB  = 64;
  localparam int LAST_BIT = 71;

endpackage : fifo_ctl_ram_pkg

// File: rtl/fifo_tpram.sv
// Two-port RAM: one synchronous write port, one synchronous registered read port.
module fifo_tpram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 72
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset so it maps onto block RAM; read-during-write returns old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= di;
    dout <= mem[raddr];
  end

endmodule : fifo_tpram

// File: rtl/fifo_ctl_ram.sv
// Show-ahead synchronous FIFO: pointer/count/flag control around fifo_tpram.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow_out/underflow_out outputs.
module fifo_ctl_ram
  import fifo_ctl_ram_pkg::*;
#(
  parameter int ADDR_LENGTH = ADDR_LENGTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   clear_in,
  input  logic                   wenable_in,
  input  logic [DATA_WIDTH-1:0]  wdata_in,
  input  logic                   renable_in,
  output logic [DATA_WIDTH-1:0]  rdata_out,
  output logic [ADDR_LENGTH-1:0] waddr_out,
  output logic [ADDR_LENGTH-1:0] raddr_out,
  output logic                   wallow_out,
  output logic                   rallow_out,
  output logic                   empty_out,
  output logic                   almost_empty_out,
  output logic                   half_full_out,
  output logic                   almost_full_out,
  output logic                   full_out
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                   overflow_out,
  output logic                   underflow_out
`endif
);

  localparam int DEPTH = 1 << ADDR_LENGTH;
  localparam int CNT_W = ADDR_LENGTH + 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(DEPTH / 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [ADDR_LENGTH-1:0] waddr, raddr, raddr_next;
  logic [CNT_W-1:0]       count, count_next;
  logic                   wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0]  ram_do, hold_data;
  logic                   hold_sel;

  assign full_out         = (count == CNT_FULL);
  assign almost_full_out  = (count >= CNT_AFULL);
  assign half_full_out    = (count >= CNT_HALF);
  assign almost_empty_out = (count <= CNT_ONE);
  assign empty_out        = (count == '0);
  assign wallow_out       = ~full_out;
  assign rallow_out       = ~empty_out;
  assign waddr_out        = waddr;
  assign raddr_out        = raddr;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    wr_acc     = wenable_in & ~full_out & ~clear_in;
    rd_acc     = renable_in & ~empty_out & ~clear_in;
    raddr_next = rd_acc ? raddr + 1'b1 : raddr;
    count_next = count;
    if (clear_in) begin
      count_next = '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      waddr <= '0;
      raddr <= '0;
      count <= '0;
    end else begin
      count <= count_next;
      if (clear_in) begin
        waddr <= '0;
        raddr <= '0;
      end else begin
        if (wr_acc) waddr <= waddr + 1'b1;
        raddr <= raddr_next;
      end
    end
  end

  // RAM is fetched at the next read pointer so the new head appears right after a pop.
  fifo_tpram #(
    .ADDR_WIDTH(ADDR_LENGTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (wb_clk_i),
    .we   (wr_acc),
    .waddr(waddr),
    .di   (wdata_in),
    .raddr(raddr_next),
    .dout (ram_do)
  );

  // Override register: forwards a word written to the address being fetched, and
  // freezes the output while the FIFO is (or becomes) empty.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      hold_sel  <= 1'b1;
      hold_data <= '0;
    end else if (wr_acc && (waddr == raddr_next)) begin
      hold_sel  <= 1'b1;
      hold_data <= wdata_in;
    end else if (count_next == '0) begin
      hold_sel  <= 1'b1;
      hold_data <= rdata_out;
    end else begin
      hold_sel  <= 1'b0;
    end
  end

  assign rdata_out = hold_sel ? hold_data : ram_do;

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else if (clear_in) begin
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      if (wenable_in && full_out)  overflow_out  <= 1'b1;
      if (renable_in && empty_out) underflow_out <= 1'b1;
    end
  end
`endif

endmodule : fifo_ctl_ram

// File: tb/tb_fifo_ctl_ram.sv
// Self-checking bench for fifo_ctl_ram against a queue-based reference model.
module tb_fifo_ctl_ram;

  localparam int AL    = 9;
  localparam int DW    = 72;
  localparam int DEPTH = 1 << AL;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b0;
  logic          clear_in = 1'b0;
  logic          wenable_in = 1'b0;
  logic [DW-1:0] wdata_in = '0;
  logic          renable_in = 1'b0;
  logic [DW-1:0] rdata_out;
  logic [AL-1:0] waddr_out, raddr_out;
  logic wallow_out, rallow_out, empty_out, almost_empty_out;
  logic half_full_out, almost_full_out, full_out;
`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_out, underflow_out;
`endif

  fifo_ctl_ram #(.ADDR_LENGTH(AL), .DATA_WIDTH(DW)) dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_i        (wb_rst_i),
    .clear_in        (clear_in),
    .wenable_in      (wenable_in),
    .wdata_in        (wdata_in),
    .renable_in      (renable_in),
    .rdata_out       (rdata_out),
    .waddr_out       (waddr_out),
    .raddr_out       (raddr_out),
    .wallow_out      (wallow_out),
    .rallow_out      (rallow_out),
    .empty_out       (empty_out),
    .almost_empty_out(almost_empty_out),
    .half_full_out   (half_full_out),
    .almost_full_out (almost_full_out),
    .full_out        (full_out)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow_out    (overflow_out),
    .underflow_out   (underflow_out)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: contents in order, plus pointer positions and sticky error bits.
  logic [DW-1:0] q[$];
  int  wp, rp;
  bit  ovf, unf;

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  function automatic logic [6:0] exp_flags();
    int n = q.size();
    return {n < DEPTH, n > 0, n == 0, n <= 1, n >= DEPTH / 2, n >= DEPTH - 2, n == DEPTH};
  endfunction

  function automatic logic [6:0] got_flags();
    return {wallow_out, rallow_out, empty_out, almost_empty_out,
            half_full_out, almost_full_out, full_out};
  endfunction

  task automatic model_reset();
    q.delete();
    wp = 0; rp = 0; ovf = 0; unf = 0;
  endtask

  // Apply one cycle of requests, advance the model at the edge, return #1 after it.
  task automatic drive(input logic we, input logic [DW-1:0] wd, input logic re, input logic clr);
    bit was_full, was_empty;
    wenable_in = we; wdata_in = wd; renable_in = re; clear_in = clr;
    @(posedge wb_clk_i);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (clr) begin
      model_reset();
    end else begin
      if (we && was_full)  ovf = 1;
      if (re && was_empty) unf = 1;
      if (re && !was_empty) begin
        void'(q.pop_front());
        rp = (rp + 1) % DEPTH;
      end
      if (we && !was_full) begin
        q.push_back(wd);
        wp = (wp + 1) % DEPTH;
      end
    end
    #1;
    wenable_in = 1'b0; renable_in = 1'b0; clear_in = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    model_reset();
    checks++;
    if (got_flags() !== 7'b1_0_1_1_0_0_0) begin
      errors++; $display("FAIL reset_flags: got %b want %b", got_flags(), 7'b1011000);
    end
    checks++;
    if (waddr_out !== '0 || raddr_out !== '0) begin
      errors++; $display("FAIL reset_ptrs: got w=%0d r=%0d want 0/0", waddr_out, raddr_out);
    end
    checks++;
    if (rdata_out !== '0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", rdata_out);
    end
`ifdef FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow_out !== 1'b0 || underflow_out !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b%b want 00", overflow_out, underflow_out);
    end
`endif
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_basic();
    drive(1'b1, 72'h11, 1'b0, 1'b0);
    checks++;
    if (empty_out !== 1'b0 || rdata_out !== 72'h11) begin
      errors++; $display("FAIL first_write: got empty=%b rdata=%h want 0/11", empty_out, rdata_out);
    end
    for (int i = 2; i <= 4; i++) drive(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
    checks++;
    if (almost_empty_out !== 1'b0 || rdata_out !== 72'h11 || waddr_out !== AL'(4)) begin
      errors++;
      $display("FAIL four_words: got ae=%b rdata=%h waddr=%0d want 0/11/4",
               almost_empty_out, rdata_out, waddr_out);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rdata_out !== DW'(8'h10 + i)) begin
        errors++; $display("FAIL pop_%0d: got %h want %h", i, rdata_out, DW'(8'h10 + i));
      end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (empty_out !== 1'b1) begin
      errors++; $display("FAIL drained: got empty=%b want 1", empty_out);
    end
  endtask

  task automatic test_fill();
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, rand_word(), 1'b0, 1'b0);
      checks++;
      if (got_flags() !== exp_flags()) begin
        errors++;
        $display("FAIL fill_flags_%0d: got %b want %b", q.size(), got_flags(), exp_flags());
      end
    end
    drive(1'b1, rand_word(), 1'b0, 1'b0);
    checks++;
    if (full_out !== 1'b1 || waddr_out !== AL'(wp) || rdata_out !== q[0] || q.size() != DEPTH) begin
      errors++;
      $display("FAIL overflow_drop: got full=%b waddr=%0d rdata=%h want 1/%0d/%h",
               full_out, waddr_out, rdata_out, wp, q[0]);
    end
`ifdef FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow_out !== 1'b1) begin
      errors++; $display("FAIL overflow_flag: got %b want 1", overflow_out);
    end
`endif
  endtask

  task automatic test_full_rw();
    drive(1'b1, rand_word(), 1'b1, 1'b0);
    checks++;
    if (full_out !== 1'b0 || almost_full_out !== 1'b1 || q.size() != DEPTH - 1 ||
        waddr_out !== AL'(wp) || raddr_out !== AL'(rp) || rdata_out !== q[0]) begin
      errors++;
      $display("FAIL full_rw: got full=%b w=%0d r=%0d rdata=%h want 0/%0d/%0d/%h",
               full_out, waddr_out, raddr_out, rdata_out, wp, rp, q[0]);
    end
    while (q.size() > 0) begin
      checks++;
      if (rdata_out !== q[0]) begin
        errors++; $display("FAIL drain_%0d: got %h want %h", q.size(), rdata_out, q[0]);
      end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (empty_out !== 1'b1 || raddr_out !== AL'(rp)) begin
      errors++;
      $display("FAIL underflow_drop: got empty=%b raddr=%0d want 1/%0d", empty_out, raddr_out, rp);
    end
`ifdef FIFO_ERR_FLAGS_EN
    checks++;
    if (underflow_out !== 1'b1) begin
      errors++; $display("FAIL underflow_flag: got %b want 1", underflow_out);
    end
`endif
  endtask

  task automatic test_empty_rw();
    drive(1'b1, 72'hAB, 1'b1, 1'b0);
    checks++;
    if (empty_out !== 1'b0 || almost_empty_out !== 1'b1 || rdata_out !== 72'hAB ||
        raddr_out !== AL'(rp)) begin
      errors++;
      $display("FAIL empty_rw: got empty=%b ae=%b rdata=%h raddr=%0d want 0/1/ab/%0d",
               empty_out, almost_empty_out, rdata_out, raddr_out, rp);
    end
  endtask

  task automatic test_stream();
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, rand_word(), 1'b1, 1'b0);
      if (rdata_out !== q[0] || empty_out !== 1'b0 || almost_empty_out !== 1'b1) begin
        bad++;
        if (bad <= 5)
          $display("FAIL stream_%0d: got rdata=%h e=%b ae=%b want %h/0/1",
                   i, rdata_out, empty_out, almost_empty_out, q[0]);
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 10; i++) drive(1'b1, rand_word(), 1'b0, 1'b0);
    drive(1'b1, rand_word(), 1'b0, 1'b1);
    checks++;
    if (empty_out !== 1'b1 || almost_empty_out !== 1'b1 || waddr_out !== '0 || raddr_out !== '0) begin
      errors++;
      $display("FAIL clear: got empty=%b ae=%b w=%0d r=%0d want 1/1/0/0",
               empty_out, almost_empty_out, waddr_out, raddr_out);
    end
`ifdef FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow_out !== 1'b0 || underflow_out !== 1'b0) begin
      errors++; $display("FAIL clear_err: got %b%b want 00", overflow_out, underflow_out);
    end
`endif
    drive(1'b1, 72'h5A, 1'b0, 1'b0);
    checks++;
    if (rdata_out !== 72'h5A || waddr_out !== AL'(1)) begin
      errors++; $display("FAIL post_clear: got rdata=%h w=%0d want 5a/1", rdata_out, waddr_out);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int phase = 0; phase < 6; phase++) begin
      int wr_pct = (phase % 2 == 0) ? 85 : 15;
      for (int i = 0; i < 700; i++) begin
        logic we, re, clr;
        we  = ($urandom_range(0, 99) < wr_pct);
        re  = ($urandom_range(0, 99) >= wr_pct) || ($urandom_range(0, 3) == 0);
        clr = ($urandom_range(0, 999) == 0);
        drive(we, rand_word(), re, clr);
        if (got_flags() !== exp_flags() || waddr_out !== AL'(wp) || raddr_out !== AL'(rp) ||
            (q.size() > 0 && rdata_out !== q[0])
`ifdef FIFO_ERR_FLAGS_EN
            || overflow_out !== ovf || underflow_out !== unf
`endif
           ) begin
          bad++;
          if (bad <= 5)
            $display("FAIL random_%0d_%0d: got flags=%b w=%0d r=%0d rdata=%h want %b/%0d/%0d/%h",
                     phase, i, got_flags(), waddr_out, raddr_out, rdata_out,
                     exp_flags(), wp, rp, (q.size() > 0) ? q[0] : rdata_out);
        end
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_stream();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_ctl_ram
